// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter / next-PC stage feeding instruction fetch
// Sequential PC advance under valid/ready, redirect with one bubble, saturating redirect count.
module pc_gen #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ready,
   input  logic             i_br_valid,
   input  logic             i_taken,
   input  logic             i_jump,
   input  logic [31:0]      i_br_pc,
   input  logic [31:0]      i_br_imm,
   output logic [31:0]      o_pc,
   output logic             o_valid,
   output logic             o_flush,
   output logic             o_misalign,
   output logic [CNT_W-1:0] o_redirects
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      BUBBLE = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] target;
   logic        redirect_req;
   logic        target_ok;

   assign target       = i_br_pc + i_br_imm;
   assign redirect_req = i_br_valid & (i_taken | i_jump);
   assign target_ok    = (target[1:0] == 2'b00);
   assign o_pc         = pc;

   // A misaligned target falls through to the normal sequencing path below.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         o_valid     <= 1'b0;
         o_flush     <= 1'b0;
         o_misalign  <= 1'b0;
         o_redirects <= '0;
      end else begin
         o_flush    <= 1'b0;
         o_misalign <= 1'b0;
         if (redirect_req && target_ok) begin
            pc      <= target;
            state   <= BUBBLE;
            o_valid <= 1'b0;
            o_flush <= 1'b1;
            if (~&o_redirects)
               o_redirects <= o_redirects + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            if (redirect_req)
               o_misalign <= 1'b1;
            case (state)
               IDLE, BUBBLE: begin
                  state   <= RUN;
                  o_valid <= 1'b1;
               end
               RUN: begin
                  o_valid <= 1'b1;
                  if (i_ready)
                     pc <= pc + 32'd4;
               end
               default: begin
                  state   <= IDLE;
                  o_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen
// Stimulus pushes expected fetches/events; a negedge monitor pops and compares.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst_n, ready, bv, tk, jp;
   logic [31:0] bpc, bimm;
   logic [31:0] o_pc;
   logic        o_valid, o_flush, o_misalign;
   logic [15:0] o_redirects;

   logic        rst2_n, ready2, bv2, tk2, jp2;
   logic [31:0] bpc2, bimm2;
   logic [31:0] o_pc2;
   logic        o_valid2, o_flush2, o_misalign2;
   logic [1:0]  o_redirects2;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] fetch_q[$];
   logic [17:0] ev_q[$];   // {flush, misalign, redirect count}

   always #5 clk = ~clk;

   pc_gen dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_ready(ready), .i_br_valid(bv),
      .i_taken(tk), .i_jump(jp), .i_br_pc(bpc), .i_br_imm(bimm),
      .o_pc(o_pc), .o_valid(o_valid), .o_flush(o_flush),
      .o_misalign(o_misalign), .o_redirects(o_redirects)
   );

   pc_gen #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst2_n), .i_ready(ready2), .i_br_valid(bv2),
      .i_taken(tk2), .i_jump(jp2), .i_br_pc(bpc2), .i_br_imm(bimm2),
      .o_pc(o_pc2), .o_valid(o_valid2), .o_flush(o_flush2),
      .o_misalign(o_misalign2), .o_redirects(o_redirects2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input logic fl, input logic mis, input logic [15:0] cnt);
      ev_q.push_back({fl, mis, cnt});
   endtask

   always @(negedge clk) begin
      if (o_valid && ready) begin
         if (fetch_q.size() == 0) chk("fetch_unexpected", o_pc, 32'hDEAD_BEEF);
         else chk("fetch_pc", o_pc, fetch_q.pop_front());
      end
      if (o_flush || o_misalign) begin
         chk("flush_mis_excl", {31'd0, o_flush & o_misalign}, 32'd0);
         if (ev_q.size() == 0) chk("event_unexpected", {14'd0, o_flush, o_misalign, o_redirects}, 32'hDEAD_BEEF);
         else chk("event", {14'd0, o_flush, o_misalign, o_redirects}, {14'd0, ev_q.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; ready = 1; bv = 0; tk = 0; jp = 0; bpc = 0; bimm = 0;
      rst2_n = 0; ready2 = 1; bv2 = 0; tk2 = 0; jp2 = 0; bpc2 = 0; bimm2 = 0;
      #2;
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_pc", o_pc, 32'h0);
      chk("rst_flush", {31'd0, o_flush}, 32'd0);
      chk("rst_mis", {31'd0, o_misalign}, 32'd0);
      chk("rst_cnt", {16'd0, o_redirects}, 32'd0);

      fetch_q.push_back(32'h0);
      fetch_q.push_back(32'h4);
      fetch_q.push_back(32'h8);
      tick(); tick();
      rst_n = 1;
      chk("idle_valid", {31'd0, o_valid}, 32'd0);
      tick();
      chk("run_valid", {31'd0, o_valid}, 32'd1);
      tick(); tick();
      ready = 0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_pc", o_pc, 32'h8);
         chk("bp_valid", {31'd0, o_valid}, 32'd1);
         tick();
      end
      ready = 1;

      // Taken branch 0x10 + (-8) -> 0x8, issued while 0x8 is being consumed
      bv = 1; tk = 1; bpc = 32'h10; bimm = 32'hFFFF_FFF8;
      fetch_q.push_back(32'h8);
      push_ev(1'b1, 1'b0, 16'd1);
      tick();
      bv = 0; tk = 0;
      chk("br_bubble_valid", {31'd0, o_valid}, 32'd0);
      chk("br_flush", {31'd0, o_flush}, 32'd1);
      tick();

      // Not-taken branch: sequential
      bv = 1; tk = 0; jp = 0;
      fetch_q.push_back(32'hC);
      tick();
      chk("nt_flush", {31'd0, o_flush}, 32'd0);

      // Misaligned jump 0x100 + 2
      jp = 1; bpc = 32'h100; bimm = 32'h2;
      fetch_q.push_back(32'h10);
      push_ev(1'b0, 1'b1, 16'd1);
      tick();

      // Back-to-back jumps to 0x40 then 0x80
      bpc = 32'h0; bimm = 32'h40;
      push_ev(1'b1, 1'b0, 16'd2);
      tick();
      bimm = 32'h80;
      push_ev(1'b1, 1'b0, 16'd3);
      tick();
      bv = 0; jp = 0;
      chk("b2b_valid", {31'd0, o_valid}, 32'd0);
      chk("b2b_pc", o_pc, 32'h80);
      chk("b2b_cnt", {16'd0, o_redirects}, 32'd3);
      fetch_q.push_back(32'h80);
      fetch_q.push_back(32'h84);
      tick(); tick(); tick();
      ready = 0;

      // Redirect while stalled, then async reset in the bubble
      bv = 1; jp = 1; bpc = 32'h0; bimm = 32'h200;
      tick();
      bv = 0; jp = 0;
      chk("stall_redir_flush", {31'd0, o_flush}, 32'd1);
      chk("stall_redir_pc", o_pc, 32'h200);
      #2;
      rst_n = 0;
      #1;
      chk("arst_valid", {31'd0, o_valid}, 32'd0);
      chk("arst_flush", {31'd0, o_flush}, 32'd0);
      chk("arst_pc", o_pc, 32'h0);
      chk("arst_cnt", {16'd0, o_redirects}, 32'd0);
      tick();
      rst_n = 1;
      ready = 1;
      fetch_q.push_back(32'h0);
      fetch_q.push_back(32'h4);
      chk("arst_idle_valid", {31'd0, o_valid}, 32'd0);
      tick(); tick(); tick();
      ready = 0;
      tick();
      chk("fetch_q_empty", fetch_q.size(), 32'd0);
      chk("ev_q_empty", ev_q.size(), 32'd0);

      // Wrap and saturation on the second instance
      rst2_n = 1;
      tick();
      chk("wrap_pc0", o_pc2, 32'hFFFF_FFF8);
      chk("wrap_valid", {31'd0, o_valid2}, 32'd1);
      tick();
      chk("wrap_pc1", o_pc2, 32'hFFFF_FFFC);
      tick();
      chk("wrap_pc2", o_pc2, 32'h0);
      bv2 = 1; jp2 = 1; bpc2 = 32'h0; bimm2 = 32'h20;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("sat_cnt", {30'd0, o_redirects2}, (i < 3) ? i + 1 : 3);
         chk("sat_flush", {31'd0, o_flush2}, 32'd1);
      end
      bv2 = 0; jp2 = 0;
      tick();
      chk("sat_pc", o_pc2, 32'h20);
      chk("sat_valid", {31'd0, o_valid2}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter / next-PC stage; consumes the branch unit's `taken` decision and produces the fetch address stream.
- Sequential PC advance under a valid/ready handshake toward instruction fetch.
- Redirects on a taken branch or a jump, flushes younger instructions and inserts one bubble cycle.
- Counts redirects for performance monitoring.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_ready  input  1  fetch stage accepts o_pc this cycle.
- i_br_valid  input  1  execute stage presents a resolved control-flow instruction.
- i_taken  input  1  branch-unit compare result; meaningful only with i_br_valid.
- i_jump  input  1  unconditional jump; redirects regardless of i_taken.
- i_br_pc  input  32  PC of the resolving instruction.
- i_br_imm  input  32  signed offset.
- o_pc  output  32  fetch address.
- o_valid  output  1  o_pc is valid.
- o_flush  output  1  one-cycle pulse: squash all younger in-flight instructions.
- o_misalign  output  1  one-cycle pulse: redirect target not word-aligned.
- o_redirects  output  CNT_W  saturating count of performed redirects.

Behaviour:
- Reset (i_rst_n=0, async):
  - state=IDLE, pc=RESET_PC.
  - o_valid=0, o_flush=0, o_misalign=0, o_redirects=0.
  - o_pc=RESET_PC.
- Definitions:
  - target = i_br_pc + i_br_imm, modulo 2^32; carry discarded.
  - redirect_req = i_br_valid & (i_taken | i_jump).
  - target_ok = (target[1:0] == 2'b00).
- States:
  - IDLE: o_valid=0. Next cycle goes to RUN. Entered only from reset; lasts exactly one cycle after reset release.
  - RUN: o_valid=1, o_pc=pc.
  - BUBBLE: o_valid=0. Lasts one cycle, then RUN.
- Priority each cycle, highest first:
  1. redirect_req & target_ok (any state):
     - pc<=target; state<=BUBBLE.
     - o_flush=1 next cycle.
     - o_redirects += 1, saturating at all-ones.
     - In RUN, a concurrent o_valid&i_ready handshake still completes (old pc consumed), but pc+4 is discarded.
  2. redirect_req & !target_ok:
     - No redirect; o_misalign=1 next cycle.
     - Otherwise behaves as if no branch this cycle.
     - Counter unchanged.
  3. RUN & i_ready: pc<=pc+4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
  4. RUN & !i_ready: pc and o_pc held stable; o_valid stays 1 (no retraction).
- Branch in BUBBLE or IDLE: redirect accepted; state (re)enters BUBBLE, o_flush pulses again, counter increments.
- i_taken / i_jump are ignored when i_br_valid=0.
- o_flush and o_misalign are registered; each is high exactly one cycle per event and never both in one cycle.
- Latency:
  - Redirect request in cycle N -> o_flush high and o_valid=0 in N+1 -> o_pc=target with o_valid=1 in N+2.
- Reset mid-operation:
  - Immediate return to reset values, including o_redirects.
  - Pending redirect is lost.
  - First fetch after release is RESET_PC following one IDLE cycle.

Test Plan:
- Reset release, RESET_PC=0, i_ready=1, no branches -> o_valid rises 1 cycle after release; o_pc = 0,4,8,C on consecutive cycles; o_flush stays 0.
- Backpressure: i_ready=0 for 3 cycles at o_pc=8 -> o_pc holds 8, o_valid=1; after i_ready=1, next o_pc=C.
- Taken branch: i_br_valid=1, i_taken=1, i_br_pc=0x10, i_br_imm=0xFFFF_FFF8 in cycle N -> o_flush=1, o_valid=0 at N+1; o_pc=0x8, o_valid=1 at N+2; o_redirects=1. Repeat with i_taken=0, i_jump=0 -> no flush, sequential PC.
- Misaligned jump: i_jump=1, i_br_pc=0x100, i_br_imm=2 -> o_misalign pulses one cycle, no flush, o_pc continues +4, counter unchanged.
- Back-to-back: jump to 0x40 at N, jump to 0x80 at N+1 (BUBBLE) -> o_flush high at N+1 and N+2; o_pc=0x80, o_valid=1 at N+3; o_redirects=2. Also preload near saturation with CNT_W=2 -> saturates at 3.
- Wrap plus async reset: RESET_PC=32'hFFFF_FFF8 -> o_pc FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert i_rst_n low mid-cycle during BUBBLE -> outputs reset immediately without a clock edge.
